trans_event_fifo: RTL

- Sits directly downstream of the signal transition detector and consumes its 12-bit per-cycle transition flag word.
- Each cycle with any flag set becomes one event word: {timestamp, flags}. Events are buffered in a FIFO and drained by the readout logic over a valid/ready handshake.
- Overflow is reported with a sticky flag and a saturating drop counter.

---
 rtl/trans_event_fifo_if.sv | 38 +++
 rtl/trans_event_fifo.sv | 107 ++++++++++
 2 files changed

// File: rtl/trans_event_fifo_if.sv
// trans_event_fifo_if: groups the event FIFO's data, handshake and status signals.
//   trans_in   - per-cycle transition flag word from the detector
//   out_data   - head event word {timestamp, flags}
//   out_valid  - FIFO not empty
//   out_ready  - consumer accepts out_data when out_valid is high
//   level      - FIFO occupancy, 0..DEPTH
//   full       - level == DEPTH
//   overflow   - sticky drop indication
//   drop_cnt   - saturating count of dropped events
//   ovf_clr    - clears overflow and drop_cnt
// The FIFO uses the slave modport; its environment uses the master modport.
interface trans_event_fifo_if #(
    parameter int unsigned DW    = 12,
    parameter int unsigned TS_W  = 16,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [DW-1:0]      trans_in;
    logic [TS_W+DW-1:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic [AW:0]        level;
    logic               full;
    logic               overflow;
    logic [15:0]        drop_cnt;
    logic               ovf_clr;

    modport slave (
        input  trans_in, out_ready, ovf_clr,
        output out_data, out_valid, level, full, overflow, drop_cnt
    );

    modport master (
        output trans_in, out_ready, ovf_clr,
        input  out_data, out_valid, level, full, overflow, drop_cnt
    );
endinterface

// File: rtl/trans_event_fifo.sv
// trans_event_fifo: turns each non-zero transition flag word into a timestamped event
// and buffers it in a FIFO drained over a valid/ready handshake.
//   clk   - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - trans_event_fifo_if slave modport (flags in, event words and status out)
// Zero flag words are never stored. When full with no simultaneous pop, events are
// dropped, overflow is set and drop_cnt counts up (saturating); ovf_clr wins over a drop.
module trans_event_fifo #(
    parameter int unsigned DW    = 12,
    parameter int unsigned TS_W  = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    trans_event_fifo_if.slave    bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = TS_W + DW;
    localparam logic [AW:0] FullLvl = (AW + 1)'(DEPTH);

    logic [EW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic [TS_W-1:0] ts_q;
    logic [EW-1:0]   head_q, head_d;
    logic            ovf_q, ovf_d;
    logic [15:0]     drop_q, drop_d;

    logic            push_req, full, empty, pop, push_acc, drop;
    logic [EW-1:0]   push_word;

    always_comb begin
        full      = (level_q == FullLvl);
        empty     = (level_q == '0);
        push_req  = |bus.trans_in;
        pop       = !empty && bus.out_ready;
        push_acc  = push_req && (!full || pop);
        drop      = push_req && full && !pop;
        push_word = {ts_q, bus.trans_in};

        wr_ptr_d  = wr_ptr_q + AW'(push_acc);
        rd_ptr_d  = rd_ptr_q + AW'(pop);

        level_d = level_q;
        unique case ({push_acc, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // Registered head view: the next head is either the word being written this
        // edge (when it lands exactly at the next read slot) or already in the RAM.
        head_d = '0;
        if (level_d != '0) begin
            if (push_acc && (rd_ptr_d == wr_ptr_q)) begin
                head_d = push_word;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end

        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (bus.ovf_clr) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end else if (drop) begin
            ovf_d  = 1'b1;
            drop_d = drop_q + 16'(drop_q != 16'hFFFF);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ts_q     <= '0;
            head_q   <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ts_q     <= ts_q + TS_W'(1);
            head_q   <= head_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    // Storage has no reset; contents are only observed through valid pointers.
    always_ff @(posedge clk) begin
        if (!reset && push_acc) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    assign bus.out_data  = head_q;
    assign bus.out_valid = !empty;
    assign bus.level     = level_q;
    assign bus.full      = full;
    assign bus.overflow  = ovf_q;
    assign bus.drop_cnt  = drop_q;
endmodule
